// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the 16-bit custom processor.
// Steps the instruction-fetch handshake, decides where the external PC goes
// (hold / increment / load), and keeps a hardware return-address stack.
// Optional build macro: SEQ_RETIRE_CNT_EN adds a live 16-bit retired
// instruction counter on retire_cnt; without it retire_cnt is tied to 0.
//
// Handshake: imem_req is raised in FETCH and stays high until imem_ack is
// seen in a FETCH cycle (the acking cycle counts); imem_ack outside FETCH is
// ignored. instr_valid marks the single EXEC cycle in which the decode inputs
// are sampled.
module pc_sequencer #(
    parameter int unsigned       ADDR_W       = 8,
    parameter int unsigned       STACK_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_select,
    output logic [ADDR_W-1:0] jump_address,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              instr_valid,
    input  logic              dec_jump,
    input  logic              dec_branch,
    input  logic              branch_taken,
    input  logic              dec_call,
    input  logic              dec_ret,
    input  logic              dec_halt,
    input  logic [ADDR_W-1:0] target_addr,
    input  logic              resume,
    output logic              halted,
    output logic              stack_overflow,
    output logic              stack_underflow,
    output logic [15:0]       retire_cnt
);

    localparam int unsigned      CNT_W    = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    // Entry 0 is always the top of stack; push/pop shift the whole array so
    // no variable index into the stack is ever needed.
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    logic              w_push;
    logic              w_pop;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic              w_empty;
    logic              w_full;
    logic [ADDR_W-1:0] w_ret_addr;

    // Return address wraps naturally at 2^ADDR_W.
    assign w_ret_addr      = pc_addr + ADDR_W'(1);
    assign w_empty         = (r_count == '0);
    assign w_full          = (r_count == FULL_CNT);
    assign stack_overflow  = r_ovf;
    assign stack_underflow = r_unf;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, PC control, handshake outputs and stack requests.
    always_comb begin
        w_next       = r_state;
        pc_select    = 1'b1;
        jump_address = pc_addr;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        halted       = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                w_next      = S_FETCH;
                if (dec_halt) begin
                    w_next = S_HALT;
                end else if (dec_ret) begin
                    if (!w_empty) begin
                        jump_address = r_stack[0];
                        w_pop        = 1'b1;
                    end else begin
                        jump_address = RESET_VECTOR;
                        w_set_unf    = 1'b1;
                    end
                end else if (dec_call) begin
                    jump_address = target_addr;
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end else if (dec_jump || (dec_branch && branch_taken)) begin
                    jump_address = target_addr;
                end else begin
                    pc_select = 1'b0;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    pc_select = 1'b0;
                    w_next    = S_FETCH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Return-address stack: shift down on push, shift up on pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_count <= '0;
        end else if (w_push) begin
            r_stack[0] <= w_ret_addr;
            for (int i = 1; i < STACK_DEPTH; i++) begin
                r_stack[i] <= r_stack[i-1];
            end
            r_count <= r_count + CNT_W'(1);
        end else if (w_pop) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                r_stack[i] <= r_stack[i+1];
            end
            r_stack[STACK_DEPTH-1] <= '0;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_set_ovf;
            r_unf <= r_unf | w_set_unf;
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] r_retire_cnt;

    // Count every instruction that leaves EXEC, halts included.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_retire_cnt <= '0;
        end else if (r_state == S_EXEC) begin
            r_retire_cnt <= r_retire_cnt + 16'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: table-driven instruction sequence, hand-written
// corner cases (reset release, halt/resume, reset during EXEC) and a random
// run against a queue-based reference model.
module tb_pc_sequencer;

  localparam int        DEPTH = 4;
  localparam logic [7:0] RV   = 8'h00;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  pc_addr;
  logic        pc_select;
  logic [7:0]  jump_address;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic        dec_jump = 1'b0;
  logic        dec_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic        dec_call = 1'b0;
  logic        dec_ret = 1'b0;
  logic        dec_halt = 1'b0;
  logic [7:0]  target_addr = 8'h00;
  logic        resume = 1'b0;
  logic        halted;
  logic        stack_overflow;
  logic        stack_underflow;
  logic [15:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rstn(rstn), .pc_addr(pc_addr), .pc_select(pc_select),
    .jump_address(jump_address), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .dec_jump(dec_jump), .dec_branch(dec_branch),
    .branch_taken(branch_taken), .dec_call(dec_call), .dec_ret(dec_ret),
    .dec_halt(dec_halt), .target_addr(target_addr), .resume(resume),
    .halted(halted), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow), .retire_cnt(retire_cnt)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  // The program counter the sequencer controls.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pc_addr <= 8'h00;
    else       pc_addr <= pc_select ? jump_address : pc_addr + 8'd1;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_retire(input string name, input int n);
`ifdef SEQ_RETIRE_CNT_EN
    chk(name, 32'(retire_cnt), 32'(n));
`else
    chk(name, 32'(retire_cnt), 32'(0));
`endif
  endtask

  task automatic clear_dec();
    dec_jump = 1'b0; dec_branch = 1'b0; branch_taken = 1'b0;
    dec_call = 1'b0; dec_ret = 1'b0; dec_halt = 1'b0; resume = 1'b0;
  endtask

  // Hold reset for a cycle, check reset outputs, release at a falling edge.
  task automatic do_reset();
    rstn = 1'b0; imem_ack = 1'b0; clear_dec();
    @(negedge clk); #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_sel", 32'(pc_select), 1);
    chk("rst_jaddr", 32'(jump_address), 32'(8'h00));
    chk("rst_ovf", 32'(stack_overflow), 0);
    chk("rst_unf", 32'(stack_underflow), 0);
    chk_retire("rst_retire", 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- table-driven instruction records ----------------
  typedef struct {
    int         ack_dly;
    logic       jmp, br, tk, call, ret;
    logic [7:0] tgt;
    logic [7:0] exp_pc;
    logic       exp_ovf, exp_unf;
  } vec_t;

  function automatic vec_t mk(input int dly, input logic j, input logic b, input logic t,
                              input logic c, input logic r, input logic [7:0] tgt,
                              input logic [7:0] epc, input logic eo, input logic eu);
    vec_t v;
    v.ack_dly = dly; v.jmp = j; v.br = b; v.tk = t; v.call = c; v.ret = r;
    v.tgt = tgt; v.exp_pc = epc; v.exp_ovf = eo; v.exp_unf = eu;
    return v;
  endfunction

  // Start in a FETCH cycle; ack after ack_dly cycles, execute, check result.
  task automatic run_instr(input vec_t v);
    int         req_cnt;
    logic [7:0] pc0;
    req_cnt = 0;
    pc0 = pc_addr;
    for (int k = 0; k <= v.ack_dly; k++) begin
      imem_ack = (k == v.ack_dly); #1;
      if (imem_req) req_cnt++;
      chk("fetch_pc_hold", 32'(pc_addr), 32'(pc0));
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dec_jump = v.jmp; dec_branch = v.br; branch_taken = v.tk;
    dec_call = v.call; dec_ret = v.ret; target_addr = v.tgt; #1;
    chk("exec_valid", 32'(instr_valid), 1);
    @(negedge clk);
    clear_dec(); #1;
    chk("fetch_req_cycles", 32'(req_cnt), 32'(v.ack_dly + 1));
    chk("next_pc", 32'(pc_addr), 32'(v.exp_pc));
    chk("ovf", 32'(stack_overflow), 32'(v.exp_ovf));
    chk("unf", 32'(stack_underflow), 32'(v.exp_unf));
  endtask

  // ---------------- reference model (random phase) ----------------
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;
  int          m_mode;
  logic [7:0]  m_pc;
  logic [7:0]  m_stk[$];
  logic        m_ovf, m_unf;
  int          m_ret;

  task automatic model_cycle();
    logic       e_sel, e_req, e_iv, e_hlt;
    logic [7:0] e_jmp;
    int         nxt;
    chk("rnd_pc", 32'(pc_addr), 32'(m_pc));
    chk("rnd_ovf", 32'(stack_overflow), 32'(m_ovf));
    chk("rnd_unf", 32'(stack_underflow), 32'(m_unf));
    chk_retire("rnd_retire", m_ret);
    e_sel = 1'b1; e_jmp = m_pc; e_req = 1'b0; e_iv = 1'b0; e_hlt = 1'b0;
    nxt = m_mode;
    case (m_mode)
      M_IDLE: nxt = M_FETCH;
      M_FETCH: begin
        e_req = 1'b1;
        if (imem_ack) nxt = M_EXEC;
      end
      M_EXEC: begin
        e_iv = 1'b1;
        nxt = M_FETCH;
        m_ret = (m_ret + 1) % 65536;
        if (dec_halt) nxt = M_HALT;
        else if (dec_ret) begin
          if (m_stk.size() > 0) e_jmp = m_stk.pop_front();
          else begin e_jmp = RV; m_unf = 1'b1; end
        end else if (dec_call) begin
          e_jmp = target_addr;
          if (m_stk.size() < DEPTH) m_stk.push_front(8'(m_pc + 8'd1));
          else m_ovf = 1'b1;
        end else if (dec_jump || (dec_branch && branch_taken)) e_jmp = target_addr;
        else e_sel = 1'b0;
      end
      default: begin
        e_hlt = 1'b1;
        if (resume) begin e_sel = 1'b0; nxt = M_FETCH; end
      end
    endcase
    chk("rnd_sel", 32'(pc_select), 32'(e_sel));
    if (e_sel) chk("rnd_jaddr", 32'(jump_address), 32'(e_jmp));
    chk("rnd_req", 32'(imem_req), 32'(e_req));
    chk("rnd_valid", 32'(instr_valid), 32'(e_iv));
    chk("rnd_halted", 32'(halted), 32'(e_hlt));
    m_pc = e_sel ? e_jmp : m_pc + 8'd1;
    m_mode = nxt;
  endtask

  // ---------------- test sequence ----------------
  vec_t       tbl[22];
  logic [7:0] exp_q[$];
  logic [6:0] exp_iv;

  initial begin
    // dly  j  b  t  c  r  tgt    exp_pc ovf unf
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 8'h10, 8'h10, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 0, 8'h40, 8'h40, 0, 0);
    tbl[3]  = mk(3, 0, 0, 0, 0, 0, 8'h00, 8'h41, 0, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 8'h80, 8'h42, 0, 0);
    tbl[5]  = mk(1, 0, 1, 1, 0, 0, 8'h05, 8'h05, 0, 0);
    tbl[6]  = mk(2, 0, 0, 0, 0, 0, 8'h00, 8'h06, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h11, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0, 8'h20, 8'h20, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 0, 8'h30, 8'h30, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 8'h50, 8'h50, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 0, 8'h70, 8'h70, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 8'h90, 8'h90, 1, 0);
    tbl[14] = mk(0, 1, 0, 0, 1, 1, 8'hAA, 8'h51, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h31, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h21, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 1, 8'h77, RV,    1, 1);
    tbl[19] = mk(0, 1, 1, 1, 0, 0, 8'h33, 8'h33, 1, 1);
    tbl[20] = mk(0, 0, 1, 1, 1, 0, 8'h44, 8'h44, 1, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h45, 1, 1);

    // Reset release with ack held high: pc 0,0,0,1,1,2,2.
    do_reset();
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02};
    exp_iv = 7'b1010100;
    imem_ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("boot_pc", 32'(pc_addr), 32'(exp_q.pop_front()));
      chk("boot_valid", 32'(instr_valid), 32'(exp_iv[i]));
      @(negedge clk);
    end
    imem_ack = 1'b0;

    // Instruction table from a clean reset.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 22; i++) run_instr(tbl[i]);
    chk_retire("table_retire", 22);

    // Reset asserted during the EXEC cycle of a call.
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; dec_call = 1'b1; target_addr = 8'h70; #1;
    chk("rstexec_valid", 32'(instr_valid), 1);
    rstn = 1'b0; #1;
    chk("rstexec_pc", 32'(pc_addr), 0);
    chk("rstexec_ovf", 32'(stack_overflow), 0);
    chk("rstexec_unf", 32'(stack_underflow), 0);
    chk("rstexec_valid_off", 32'(instr_valid), 0);
    chk_retire("rstexec_retire", 0);
    @(negedge clk);
    clear_dec(); rstn = 1'b1;
    @(negedge clk);
    run_instr(mk(0, 0, 0, 0, 0, 1, 8'h00, RV, 0, 1));

    // Halt wins over call and jump; decode ignored while halted; resume.
    do_reset();
    @(negedge clk);
    run_instr(mk(0, 1, 0, 0, 0, 0, 8'h20, 8'h20, 0, 0));
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; dec_halt = 1'b1; dec_call = 1'b1; dec_jump = 1'b1; target_addr = 8'h40; #1;
    chk("halt_exec_valid", 32'(instr_valid), 1);
    @(negedge clk);
    clear_dec();
    for (int i = 0; i < 3; i++) begin
      dec_jump = 1'b1; dec_call = 1'b1; target_addr = 8'h77; imem_ack = 1'b1; #1;
      chk("halt_flag", 32'(halted), 1);
      chk("halt_req", 32'(imem_req), 0);
      chk("halt_pc", 32'(pc_addr), 32'(8'h20));
      chk("halt_sel", 32'(pc_select), 1);
      chk("halt_jaddr", 32'(jump_address), 32'(8'h20));
      @(negedge clk);
    end
    clear_dec(); imem_ack = 1'b0; resume = 1'b1; #1;
    chk("resume_sel", 32'(pc_select), 0);
    @(negedge clk);
    resume = 1'b0; #1;
    chk("resume_pc", 32'(pc_addr), 32'(8'h21));
    chk("resume_req", 32'(imem_req), 1);
    chk("resume_halted", 32'(halted), 0);
    run_instr(mk(0, 0, 0, 0, 0, 1, 8'h00, RV, 0, 1));
    chk_retire("halt_retire", 3);

    // Random run against the reference model.
    do_reset();
    m_mode = M_IDLE; m_pc = 8'h00; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_ret = 0;
    for (int c = 0; c < 4000; c++) begin
      imem_ack     = 1'($urandom_range(0, 1));
      dec_halt     = ($urandom_range(0, 15) == 0);
      dec_ret      = ($urandom_range(0, 3) == 0);
      dec_call     = ($urandom_range(0, 3) == 0);
      dec_jump     = ($urandom_range(0, 5) == 0);
      dec_branch   = ($urandom_range(0, 2) == 0);
      branch_taken = 1'($urandom_range(0, 1));
      resume       = ($urandom_range(0, 2) == 0);
      target_addr  = 8'($urandom_range(0, 255));
      #1;
      model_cycle();
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
